// File: rtl/fp_pkg.sv
// Shared floating-point helpers: FSM state encoding and default field widths
// used by the normalization datapath.
package fp_pkg;

   // Default half-precision-style field widths (mantissa includes hidden bit).
   localparam int MANT_W_DEF = 11;
   localparam int EXP_W_DEF  = 5;

   // Normalizer control states.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } norm_state_t;

endpackage : fp_pkg

// File: rtl/fp_norm_shifter_dec1fromval.sv
// Decrement-by-one with enable; counterpart of the increment-by-one block.
// When disabled the value passes through unchanged.
module dec1fromval #(
   parameter int W = 5
) (
   input  logic         en,
   input  logic [W-1:0] val,
   output logic [W-1:0] result
);

   // Subtract one only when enabled; callers guarantee val != 0 when en = 1.
   always_comb begin
      result = en ? (val - W'(1)) : val;
   end

endmodule : dec1fromval

// File: rtl/fp_norm_shifter.sv
// Sequential normalizer: shifts an unnormalized mantissa left one bit per
// cycle, decrementing the exponent, until the MSB is set, the mantissa is
// found to be zero, or the exponent bottoms out at zero (denormal result).
module fp_norm_shifter
   import fp_pkg::*;
#(
   parameter int MANT_W = MANT_W_DEF,
   parameter int EXP_W  = EXP_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [MANT_W-1:0] mant_in,
   input  logic [EXP_W-1:0]  exp_in,
   output logic              busy,
   output logic              done,
   output logic [MANT_W-1:0] mant_out,
   output logic [EXP_W-1:0]  exp_out,
   output logic              zero,
   output logic              underflow
);

   norm_state_t       state, state_nxt;
   logic [MANT_W-1:0] mant_r, mant_nxt;
   logic [EXP_W-1:0]  exp_r, exp_nxt;
   logic              zero_r, zero_nxt;
   logic              uf_r, uf_nxt;
   logic              dec_en;
   logic [EXP_W-1:0]  exp_dec;

   // Exponent decrementer, enabled only on a shift step (exponent is nonzero then).
   dec1fromval #(.W(EXP_W)) u_dec (
      .en     (dec_en),
      .val    (exp_r),
      .result (exp_dec)
   );

   // Next-state and working-register update decisions.
   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
      state_nxt = state;
      mant_nxt  = mant_r;
      exp_nxt   = exp_r;
      zero_nxt  = zero_r;
      uf_nxt    = uf_r;
      dec_en    = 1'b0;
      case (state)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               mant_nxt  = mant_in;
               exp_nxt   = exp_in;
               zero_nxt  = 1'b0;
               uf_nxt    = 1'b0;
               state_nxt = ST_SHIFT;
            end else begin
               state_nxt = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            if (mant_r == '0) begin
               mant_nxt  = '0;
               exp_nxt   = '0;
               zero_nxt  = 1'b1;
               state_nxt = ST_DONE;
            end else if (mant_r[MANT_W-1]) begin
               state_nxt = ST_DONE;
            end else if (exp_r == '0) begin
               uf_nxt    = 1'b1;
               state_nxt = ST_DONE;
            end else begin
               mant_nxt = {mant_r[MANT_W-2:0], 1'b0};
               dec_en   = 1'b1;
               exp_nxt  = exp_dec;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // State register; reset aborts any request in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: non-blocking assignments so all flops update together from pre-edge values.
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   // Working registers holding mantissa, exponent and status flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mant_r <= '0;
         exp_r  <= '0;
         zero_r <= 1'b0;
         uf_r   <= 1'b0;
      end else begin
         mant_r <= mant_nxt;
         exp_r  <= exp_nxt;
         zero_r <= zero_nxt;
         uf_r   <= uf_nxt;
      end
   end

   assign busy      = (state == ST_SHIFT);
   assign done      = (state == ST_DONE);
   assign mant_out  = mant_r;
   assign exp_out   = exp_r;
   assign zero      = zero_r;
   assign underflow = uf_r;

endmodule : fp_norm_shifter

// File: tb/tb_fp_norm_shifter.sv
// Directed bench for fp_norm_shifter: normal, zero, denormal, max-latency,
// ignored re-start, mid-request reset and first-edge-after-reset cases.
module tb_fp_norm_shifter;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [10:0] mant_in;
   logic [4:0]  exp_in;
   logic        busy;
   logic        done;
   logic [10:0] mant_out;
   logic [4:0]  exp_out;
   logic        zero;
   logic        underflow;

   int n_checks = 0;
   int n_pass   = 0;

   fp_norm_shifter dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .mant_in   (mant_in),
      .exp_in    (exp_in),
      .busy      (busy),
      .done      (done),
      .mant_out  (mant_out),
      .exp_out   (exp_out),
      .zero      (zero),
      .underflow (underflow)
   );

   // 10 ns clock, rising edges at 5, 15, 25, ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      if (obs === exp_v) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
   endtask

   // Issue one request and follow it to its done pulse, counting rising edges
   // with the start-sampling edge as edge 1. repulse_edge > 0 re-asserts start
   // with other data while in SHIFT; rel_rst releases reset together with start.
   task automatic run_req(input string tag,
                          input logic [10:0] m, input logic [4:0] e,
                          input int exp_edge,
                          input logic [10:0] exp_m, input logic [4:0] exp_e,
                          input logic exp_z, input logic exp_uf,
                          input int repulse_edge, input bit rel_rst);
      int edge_n;
      @(negedge clk);
      if (rel_rst) rst_n = 1'b1;
      mant_in = m;
      exp_in  = e;
      start   = 1'b1;
      @(posedge clk); #1;
      start  = 1'b0;
      edge_n = 1;
      check({tag, ".busy1"}, busy, 1);
      while (!done && edge_n < 20) begin
         if (edge_n == repulse_edge) begin
            mant_in = 11'h400;
            exp_in  = 5'd7;
            start   = 1'b1;
         end
         @(posedge clk); #1;
         start = 1'b0;
         edge_n++;
      end
      check({tag, ".done"}, done, 1);
      check({tag, ".edge"}, edge_n, exp_edge);
      check({tag, ".mant"}, mant_out, exp_m);
      check({tag, ".exp"}, exp_out, exp_e);
      check({tag, ".zero"}, zero, exp_z);
      check({tag, ".uf"}, underflow, exp_uf);
      check({tag, ".busy_dn"}, busy, 0);
      @(posedge clk); #1;
      check({tag, ".done_1cyc"}, done, 0);
      check({tag, ".hold"}, {mant_out, exp_out, zero, underflow}, {exp_m, exp_e, exp_z, exp_uf});
   endtask

   initial begin
      int done_seen;
      rst_n   = 1'b0;
      start   = 1'b0;
      mant_in = '0;
      exp_in  = '0;
      #12;
      check("reset.outs", {busy, done, mant_out, exp_out, zero, underflow}, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Already normalized: no shifts.
      run_req("norm", 11'b100_0000_0000, 5'd15, 2, 11'b100_0000_0000, 5'd15, 0, 0, 0, 0);
      // Eight shifts.
      run_req("shift8", 11'b000_0000_0101, 5'd20, 10, 11'b101_0000_0000, 5'd12, 0, 0, 0, 0);
      // Exact zero.
      run_req("zero", 11'd0, 5'd9, 2, 11'd0, 5'd0, 1, 0, 0, 0);
      // Zero flag cleared by the next request.
      run_req("clrz", 11'b010_0000_0000, 5'd4, 3, 11'b100_0000_0000, 5'd3, 0, 0, 0, 0);
      // Exponent bottoms out: denormal.
      run_req("uflow", 11'b000_0000_0001, 5'd3, 5, 11'b000_0000_1000, 5'd0, 0, 1, 0, 0);
      // Exponent already zero with nonzero mantissa.
      run_req("uflow0", 11'b000_0000_0011, 5'd0, 2, 11'b000_0000_0011, 5'd0, 0, 1, 0, 0);
      // Maximum latency, MANT_W+1 edges.
      run_req("maxlat", 11'b000_0000_0001, 5'd20, 12, 11'b100_0000_0000, 5'd10, 0, 0, 0, 0);
      // Re-start mid-SHIFT is ignored.
      run_req("repulse", 11'b000_0000_0001, 5'd20, 12, 11'b100_0000_0000, 5'd10, 0, 0, 3, 0);

      // Reset mid-SHIFT: asynchronous clear, no stray done afterwards.
      @(negedge clk);
      mant_in = 11'b000_0000_0001;
      exp_in  = 5'd20;
      start   = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      check("rstmid.busy", busy, 1);
      #2 rst_n = 1'b0;
      #1;
      check("rstmid.async", {busy, done, mant_out, exp_out, zero, underflow}, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n     = 1'b1;
      done_seen = 0;
      repeat (14) begin
         @(posedge clk); #1;
         if (done || busy) done_seen++;
      end
      check("rstmid.nodone", done_seen, 0);
      run_req("after_rst", 11'b001_1000_0000, 5'd10, 4, 11'b110_0000_0000, 5'd8, 0, 0, 0, 0);

      // Start accepted on the first rising edge after reset release.
      #3 rst_n = 1'b0;
      run_req("first_edge", 11'b000_1000_0000, 5'd5, 5, 11'b100_0000_0000, 5'd2, 0, 0, 0, 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_fp_norm_shifter
